// File: rtl/wb_bram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_bram_pkg
//  Brief    : Shared types and helpers for the Wishbone true dual-port BRAM.
//  Revision : 1.0  initial release
// ============================================================================
package wb_bram_pkg;

    localparam int BYTE_WIDTH_DEFAULT = 8;

    // Number of byte lanes in one data word.
    function automatic int lanes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    // One completion-pipeline entry.
    typedef struct packed {
        logic valid;
        logic is_err;
    } cpl_t;

endpackage
`default_nettype wire

// File: rtl/bram_tdp_core.sv
`default_nettype none
// ============================================================================
//  Module   : bram_tdp_core
//  Brief    : Raw two-port, byte-enabled, read-first RAM array. When both
//             ports write the same word in one cycle, port A owns every lane
//             it selects; lanes selected by only one port take that port.
//  Revision : 1.0  initial release
// ============================================================================
module bram_tdp_core
    import wb_bram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = BYTE_WIDTH_DEFAULT,
    parameter int DEPTH      = 16384,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    localparam int LANES     = lanes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_adr,
    input  logic [LANES-1:0]      a_sel,
    input  logic [DATA_WIDTH-1:0] a_dat,
    output logic [DATA_WIDTH-1:0] a_rdat,
    input  logic                  b_en,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_adr,
    input  logic [LANES-1:0]      b_sel,
    input  logic [DATA_WIDTH-1:0] b_dat,
    output logic [DATA_WIDTH-1:0] b_rdat
);

    logic [LANES-1:0][BYTE_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]            a_rdat_q;
    logic [DATA_WIDTH-1:0]            b_rdat_q;

    // Reads sample the word before this edge's writes land (read-first);
    // port A lanes are assigned last so they override port B on a collision.
    always_ff @(posedge clk) begin
        if (a_en && !a_we) a_rdat_q <= mem_q[a_adr];
        if (b_en && !b_we) b_rdat_q <= mem_q[b_adr];
        for (int k = 0; k < LANES; k++) begin
            if (b_en && b_we && b_sel[k])
                mem_q[b_adr][k] <= b_dat[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
        for (int k = 0; k < LANES; k++) begin
            if (a_en && a_we && a_sel[k])
                mem_q[a_adr][k] <= a_dat[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    assign a_rdat = a_rdat_q;
    assign b_rdat = b_rdat_q;

endmodule
`default_nettype wire

// File: rtl/wb_tdp_bram.sv
`default_nettype none
// ============================================================================
//  Module   : wb_tdp_bram
//  Brief    : True dual-port byte-enabled BRAM with two Wishbone B4 pipelined
//             slave ports. Out-of-range requests complete with err and never
//             touch the array; dropping cyc flushes that port's completions.
//             Build option WB_TDP_BRAM_OUTREG_EN adds an output register per
//             port (completion latency 2 instead of 1).
//  Revision : 1.0  initial release
// ============================================================================
module wb_tdp_bram
    import wb_bram_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BYTE_WIDTH  = BYTE_WIDTH_DEFAULT,
    parameter int DEPTH       = 16384,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int LANES      = lanes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_cyc_i,
    input  logic                  a_stb_i,
    input  logic                  a_we_i,
    input  logic [ADDR_WIDTH-1:0] a_adr_i,
    input  logic [LANES-1:0]      a_sel_i,
    input  logic [DATA_WIDTH-1:0] a_dat_i,
    output logic [DATA_WIDTH-1:0] a_dat_o,
    output logic                  a_ack_o,
    output logic                  a_err_o,
    output logic                  a_stall_o,
    input  logic                  b_cyc_i,
    input  logic                  b_stb_i,
    input  logic                  b_we_i,
    input  logic [ADDR_WIDTH-1:0] b_adr_i,
    input  logic [LANES-1:0]      b_sel_i,
    input  logic [DATA_WIDTH-1:0] b_dat_i,
    output logic [DATA_WIDTH-1:0] b_dat_o,
    output logic                  b_ack_o,
    output logic                  b_err_o,
    output logic                  b_stall_o
);

`ifdef WB_TDP_BRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    // Both ports packed into index 0 (A) / 1 (B) so one front end serves both.
    logic [1:0]            cyc, stb, we, en, ack, err;
    logic [ADDR_WIDTH-1:0] adr       [2];
    logic [LANES-1:0]      sel       [2];
    logic [DATA_WIDTH-1:0] wdat      [2];
    logic [DATA_WIDTH-1:0] rdat_core [2];
    logic [DATA_WIDTH-1:0] rdat      [2];
    logic [DATA_WIDTH-1:0] dat_out   [2];

    assign cyc     = {b_cyc_i, a_cyc_i};
    assign stb     = {b_stb_i, a_stb_i};
    assign we      = {b_we_i,  a_we_i};
    assign adr[0]  = a_adr_i;
    assign adr[1]  = b_adr_i;
    assign sel[0]  = a_sel_i;
    assign sel[1]  = b_sel_i;
    assign wdat[0] = a_dat_i;
    assign wdat[1] = b_dat_i;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            logic              accept;
            logic              in_range;
            cpl_t [LAT-1:0]    cpl_d, cpl_q;
            logic [LAT-1:0]    rd_d, rd_q;

            assign accept   = cyc[p] & stb[p];
            assign in_range = {1'b0, adr[p]} < DEPTH_W;
            assign en[p]    = accept & in_range;

            // New completion enters stage 0; older ones advance unless cyc drops.
            always_comb begin
                cpl_d           = '0;
                rd_d            = '0;
                cpl_d[0].valid  = accept;
                cpl_d[0].is_err = accept & ~in_range;
                rd_d[0]         = en[p] & ~we[p];
                for (int s = 1; s < LAT; s++) begin
                    cpl_d[s].valid  = cpl_q[s-1].valid & cyc[p];
                    cpl_d[s].is_err = cpl_q[s-1].is_err;
                    rd_d[s]         = rd_q[s-1];
                end
            end

            // Completion state; reset discards everything in flight.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cpl_q <= '0;
                    rd_q  <= '0;
                end else begin
                    cpl_q <= cpl_d;
                    rd_q  <= rd_d;
                end
            end

`ifdef WB_TDP_BRAM_OUTREG_EN
            logic [DATA_WIDTH-1:0] rdat_d, rdat_q;

            always_comb begin
                rdat_d = rdat_core[p];
            end

            // Extra output register behind the array.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) rdat_q <= '0;
                else        rdat_q <= rdat_d;
            end

            assign rdat[p] = rdat_q;
`else
            assign rdat[p] = rdat_core[p];
`endif

            // A low cyc hides the last stage too, so nothing completes while it is low.
            assign ack[p]     = cpl_q[LAT-1].valid & ~cpl_q[LAT-1].is_err & cyc[p];
            assign err[p]     = cpl_q[LAT-1].valid &  cpl_q[LAT-1].is_err & cyc[p];
            assign dat_out[p] = (ack[p] & rd_q[LAT-1]) ? rdat[p] : '0;
        end
    endgenerate

    bram_tdp_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk    (clk),
        .a_en   (en[0]),
        .a_we   (we[0]),
        .a_adr  (adr[0]),
        .a_sel  (sel[0]),
        .a_dat  (wdat[0]),
        .a_rdat (rdat_core[0]),
        .b_en   (en[1]),
        .b_we   (we[1]),
        .b_adr  (adr[1]),
        .b_sel  (sel[1]),
        .b_dat  (wdat[1]),
        .b_rdat (rdat_core[1])
    );

    assign a_ack_o   = ack[0];
    assign a_err_o   = err[0];
    assign a_dat_o   = dat_out[0];
    assign a_stall_o = 1'b0;
    assign b_ack_o   = ack[1];
    assign b_err_o   = err[1];
    assign b_dat_o   = dat_out[1];
    assign b_stall_o = 1'b0;

endmodule
`default_nettype wire
